// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch queue
package fetch_pkg;

  localparam int          FETCH_DEPTH = 4;
  localparam logic [31:0] NOP         = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through FIFO with a registered head stage
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int BODY = DEPTH - 1;
  localparam int PW   = (BODY > 1) ? $clog2(BODY) : 1;
  localparam int CW   = $clog2(DEPTH + 1);

  // The head lives in its own register so rd_data/rd_valid come straight from flops;
  // the remaining DEPTH-1 entries sit behind it in a small circular buffer.
  logic [WIDTH-1:0] body_mem [BODY];
  logic [WIDTH-1:0] head_q;
  logic             head_valid_q;
  logic [PW-1:0]    wptr_q;
  logic [PW-1:0]    rptr_q;
  logic [CW-1:0]    body_cnt_q;

  logic pop;
  logic head_from_body;
  logic head_from_in;
  logic body_push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BODY - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pop = rd_en && head_valid_q;

  always_comb begin
    head_from_body = 1'b0;
    head_from_in   = 1'b0;
    body_push      = 1'b0;
    if (!head_valid_q || pop) begin
      if (body_cnt_q != '0) begin
        head_from_body = 1'b1;
        body_push      = wr_en;
      end else begin
        head_from_in = wr_en;
      end
    end else begin
      body_push = wr_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q       <= '0;
      head_valid_q <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      body_cnt_q   <= '0;
    end else if (flush) begin
      head_valid_q <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      body_cnt_q   <= '0;
    end else begin
      if (head_from_body) begin
        head_q       <= body_mem[rptr_q];
        head_valid_q <= 1'b1;
      end else if (head_from_in) begin
        head_q       <= wr_data;
        head_valid_q <= 1'b1;
      end else if (pop) begin
        head_valid_q <= 1'b0;
      end
      if (body_push)      wptr_q <= ptr_inc(wptr_q);
      if (head_from_body) rptr_q <= ptr_inc(rptr_q);
      case ({body_push, head_from_body})
        2'b10:   body_cnt_q <= body_cnt_q + CW'(1);
        2'b01:   body_cnt_q <= body_cnt_q - CW'(1);
        default: body_cnt_q <= body_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && body_push) begin
      body_mem[wptr_q] <= wr_data;
    end
  end

  assign rd_data  = head_q;
  assign rd_valid = head_valid_q;
  assign count    = body_cnt_q + CW'(head_valid_q);

endmodule

// File: rtl/imem_fetch_queue.sv
// rtl/imem_fetch_queue.sv - sequential instruction fetch with in-order response queue and redirect drain
module imem_fetch_queue
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = FETCH_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]  fetch_pc_q;
  logic [CW-1:0] outstanding_q;
  logic [CW-1:0] outstanding_d;
  logic [CW-1:0] discard_q;
  logic [CW-1:0] discard_d;
  logic [CW-1:0] q_count;
  logic [CW-1:0] live;
  logic [CW:0]   occupancy;
  fetch_state_e  state_q;
  fetch_state_e  state_d;

  logic         gnt_fire;
  logic         rsp_fire;
  logic         push;
  logic [31:0]  rsp_pc;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;

  // Requests are only issued when every possible response already has a queue slot.
  assign occupancy  = {1'b0, outstanding_q} + {1'b0, q_count};
  assign mem_req_o  = !rst && !redirect_i && (occupancy < (CW+1)'(DEPTH));
  assign mem_addr_o = fetch_pc_q;
  assign gnt_fire   = mem_req_o && mem_gnt_i;
  assign rsp_fire   = mem_rvalid_i && (outstanding_q != '0);

  assign outstanding_d = outstanding_q + CW'(gnt_fire) - CW'(rsp_fire);

  // Live requests are contiguous and end just below fetch_pc, so the oldest one
  // is fetch_pc minus four times their number; stale ones are already excluded.
  assign live   = outstanding_q - discard_q;
  assign rsp_pc = fetch_pc_q - {{(30-CW){1'b0}}, live, 2'b00};

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    push      = 1'b0;
    case (state_q)
      ST_RUN: begin
        push = rsp_fire;
      end
      ST_DRAIN: begin
        if (rsp_fire) begin
          discard_d = discard_q - CW'(1);
          if (discard_q == CW'(1)) state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
    if (redirect_i) begin
      push      = 1'b0;
      discard_d = outstanding_d;
      state_d   = (outstanding_d != '0) ? ST_DRAIN : ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      state_q       <= ST_RUN;
    end else begin
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      state_q       <= state_d;
      if (redirect_i)    fetch_pc_q <= word_align(redirect_pc_i);
      else if (gnt_fire) fetch_pc_q <= fetch_pc_q + 32'd4;
    end
  end

  assign push_entry.pc    = rsp_pc;
  assign push_entry.instr = mem_rdata_i;

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_i),
    .wr_en    (push),
    .wr_data  (push_entry),
    .rd_en    (inst_ready_i),
    .rd_data  (head_entry),
    .rd_valid (inst_valid_o),
    .count    (q_count)
  );

  assign inst_o    = head_entry.instr;
  assign inst_pc_o = head_entry.pc;

endmodule

// File: tb/tb_imem_fetch_queue.sv
// tb/tb_imem_fetch_queue.sv - directed self-checking bench for imem_fetch_queue
module tb_imem_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b1;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b1;

  int vecs = 0;
  int errs = 0;
  int lat = 1;
  int n_gnt = 0;
  int edge_cnt = 0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] rec_pc[$];
  logic [31:0] rec_ins[$];

  imem_fetch_queue dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .mem_req_o     (mem_req),
    .mem_addr_o    (mem_addr),
    .mem_gnt_i     (mem_gnt),
    .mem_rvalid_i  (mem_rvalid),
    .mem_rdata_i   (mem_rdata),
    .inst_valid_o  (inst_valid),
    .inst_o        (inst),
    .inst_pc_o     (inst_pc),
    .inst_ready_i  (inst_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  always @(posedge clk) edge_cnt = edge_cnt + 1;

  // Memory: grants per mem_gnt, answers in order exactly lat edges after the grant edge.
  always @(negedge clk) begin
    int e;
    e = edge_cnt + 1;
    if (rst) begin
      pend_addr.delete();
      pend_due.delete();
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
    end else begin
      mem_rvalid = 1'b0;
      if (pend_due.size() > 0 && pend_due[0] == e) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_word(pend_addr[0]);
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (mem_req && mem_gnt) begin
        pend_addr.push_back(mem_addr);
        pend_due.push_back(e + lat);
        n_gnt = n_gnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (inst_valid && inst_ready) begin
      rec_pc.push_back(inst_pc);
      rec_ins.push_back(inst);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs = vecs + 1;
    assert (got === exp) else begin
      errs = errs + 1;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rpc(input int k);
    return (rec_pc.size() > k) ? rec_pc[k] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] rins(input int k);
    return (rec_ins.size() > k) ? rec_ins[k] : 32'hDEAD_BEEF;
  endfunction

  task automatic do_reset(input int new_lat);
    rst = 1'b1;
    redirect = 1'b0;
    tick();
    lat = new_lat;
    tick();
  endtask

  initial begin
    logic stale;

    // Reset state
    tick();
    tick();
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_pc", inst_pc, 32'd0);

    // Streaming with 1-cycle memory
    rst = 1'b0;
    #1;
    chk("strm_req0", {31'b0, mem_req}, 32'd1);
    chk("strm_addr0", mem_addr, 32'h0);
    chk("strm_c1_valid", {31'b0, inst_valid}, 32'd0);
    tick();
    chk("strm_c2_valid", {31'b0, inst_valid}, 32'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("strm_valid", {31'b0, inst_valid}, 32'd1);
      chk("strm_pc", inst_pc, 32'(4 * i));
      chk("strm_inst", inst, mem_word(32'(4 * i)));
      tick();
    end

    // Back-pressure
    inst_ready = 1'b0;
    do_reset(1);
    n_gnt = 0;
    rst = 1'b0;
    repeat (10) tick();
    chk("bp_grants", 32'(n_gnt), 32'd4);
    chk("bp_req_low", {31'b0, mem_req}, 32'd0);
    rec_pc.delete();
    rec_ins.delete();
    inst_ready = 1'b1;
    repeat (8) tick();
    for (int k = 0; k < 4; k++) begin
      chk("bp_pc", rpc(k), 32'(4 * k));
      chk("bp_inst", rins(k), mem_word(32'(4 * k)));
    end

    // Redirect with 3 requests in flight
    do_reset(4);
    rst = 1'b0;
    tick();
    tick();
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h200;
    #1;
    chk("rd3_req_withdrawn", {31'b0, mem_req}, 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    chk("rd3_valid_after", {31'b0, inst_valid}, 32'd0);
    chk("rd3_req_after", {31'b0, mem_req}, 32'd1);
    chk("rd3_addr_after", mem_addr, 32'h200);
    rec_pc.delete();
    rec_ins.delete();
    repeat (16) tick();
    chk("rd3_pc0", rpc(0), 32'h200);
    chk("rd3_inst0", rins(0), mem_word(32'h200));
    chk("rd3_pc1", rpc(1), 32'h204);
    chk("rd3_pc2", rpc(2), 32'h208);
    stale = 1'b0;
    foreach (rec_pc[j]) if (rec_pc[j] < 32'h200) stale = 1'b1;
    chk("rd3_no_stale", {31'b0, stale}, 32'd0);

    // Redirect to an unaligned target
    do_reset(1);
    rst = 1'b0;
    repeat (5) tick();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0102;
    #1;
    chk("ua_req_withdrawn", {31'b0, mem_req}, 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    chk("ua_addr", mem_addr, 32'h100);
    chk("ua_valid_after", {31'b0, inst_valid}, 32'd0);
    rec_pc.delete();
    rec_ins.delete();
    repeat (6) tick();
    chk("ua_pc0", rpc(0), 32'h100);
    chk("ua_inst0", rins(0), mem_word(32'h100));

    // Grant withheld, then redirect
    mem_gnt = 1'b0;
    do_reset(1);
    n_gnt = 0;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_req", {31'b0, mem_req}, 32'd1);
      chk("hold_addr", mem_addr, 32'h0);
      tick();
    end
    redirect = 1'b1;
    redirect_pc = 32'h40;
    mem_gnt = 1'b1;
    #1;
    chk("hold_req_withdrawn", {31'b0, mem_req}, 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    chk("hold_no_grants", 32'(n_gnt), 32'd0);
    chk("hold_addr_new", mem_addr, 32'h40);
    rec_pc.delete();
    rec_ins.delete();
    repeat (5) tick();
    chk("hold_pc0", rpc(0), 32'h40);
    chk("hold_inst0", rins(0), mem_word(32'h40));

    // Reset with 2 requests outstanding
    do_reset(4);
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_req_now", {31'b0, mem_req}, 32'd0);
    tick();
    chk("mid_rst_req", {31'b0, mem_req}, 32'd0);
    chk("mid_rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("mid_rst_inst", inst, 32'd0);
    chk("mid_rst_pc", inst_pc, 32'd0);
    tick();
    rst = 1'b0;
    rec_pc.delete();
    rec_ins.delete();
    #1;
    chk("mid_rst_first_addr", mem_addr, 32'h0);
    repeat (12) tick();
    chk("mid_rst_pc0", rpc(0), 32'h0);
    chk("mid_rst_inst0", rins(0), mem_word(32'h0));
    chk("mid_rst_pc1", rpc(1), 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
